// File: rtl/rr_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | rr_arbiter : round-robin N:1 valid/ready arbiter, grant held while valid.   |
// | Optional macro RR_ARBITER_CHECKS_EN enables simulation-only assertions.     |
// | Revision  : 1.0                                                             |
// +-----------------------------------------------------------------------------+
module rr_arbiter #(
  parameter int N = 128,
  parameter int D = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N-1:0]     i_valid,
  output logic [N-1:0]     o_ready,
  input  logic [N*D-1:0]   i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [D-1:0]     o_data
);

  localparam int PW = $clog2(N);

  logic [N-1:0]  r_grant;
  logic [PW-1:0] r_ptr;

  logic [N-1:0]  w_gv;
  logic          w_hold;
  logic          w_any;
  logic          w_found;
  logic [PW-1:0] w_cand;
  logic [PW-1:0] w_next_idx;

  assign w_gv   = r_grant & i_valid;
  assign w_hold = |w_gv;
  assign w_any  = |i_valid;

  // First valid requester at or after ptr+1, wrapping modulo N.
  always_comb begin
    w_found    = 1'b0;
    w_cand     = r_ptr;
    w_next_idx = r_ptr;
    for (int i = 1; i <= N; i++) begin
      w_cand = PW'((int'(r_ptr) + i) % N);
      if (!w_found && i_valid[w_cand]) begin
        w_found    = 1'b1;
        w_next_idx = w_cand;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_grant <= '0;
      r_ptr   <= PW'(N - 1);
    end else if (!w_hold) begin
      if (w_any) begin
        r_grant <= {{(N-1){1'b0}}, 1'b1} << w_next_idx;
        r_ptr   <= w_next_idx;
      end else begin
        r_grant <= '0;
      end
    end
  end

  assign o_valid = w_hold;
  assign o_ready = w_gv & {N{i_ready}};

  always_comb begin
    o_data = '0;
    for (int k = 0; k < N; k++) begin
      if (w_gv[k]) begin
        o_data = o_data | i_data[k*D +: D];
      end
    end
  end

`ifdef RR_ARBITER_CHECKS_EN
  always @(posedge i_clk) begin
    if (i_rst_n) begin
      assert ($onehot0(o_ready))
        else $error("rr_arbiter: o_ready not zero/one-hot: %h", o_ready);
      assert ((o_ready & ~i_valid) == '0)
        else $error("rr_arbiter: o_ready %h not subset of i_valid %h", o_ready, i_valid);
      assert ($onehot0(r_grant))
        else $error("rr_arbiter: grant not zero/one-hot: %h", r_grant);
    end
  end

  assert property (@(posedge i_clk) disable iff (!i_rst_n) w_hold |=> $stable(r_grant))
    else $error("rr_arbiter: grant changed while grantee held valid");
`else
  // No checks compiled in this build.
`endif

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter.sv
`default_nettype none
// Directed self-checking bench for rr_arbiter with N=4, D=8, data slice k = k.
module tb_rr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  valid;
  logic [3:0]  ready_o;
  logic [31:0] data;
  logic        o_valid;
  logic        i_ready;
  logic [7:0]  o_data;

  int checks = 0;
  int errors = 0;

  rr_arbiter #(.N(4), .D(8)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (valid),
    .o_ready (ready_o),
    .i_data  (data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [3:0] r, input logic [7:0] d);
    #1;
    chk({tag, "_valid"}, 32'(o_valid), 32'(v));
    chk({tag, "_ready"}, 32'(ready_o), 32'(r));
    chk({tag, "_data"},  32'(o_data),  32'(d));
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Grant k appears on the next edge, is held 3 cycles, then k drops valid.
  task automatic serve(input int k);
    tick();
    expect_out($sformatf("grant%0d", k), 1'b1, 4'(1 << k), 8'(k));
    tick();
    expect_out($sformatf("hold%0d_a", k), 1'b1, 4'(1 << k), 8'(k));
    tick();
    expect_out($sformatf("hold%0d_b", k), 1'b1, 4'(1 << k), 8'(k));
    tick();
    valid[k] = 1'b0;
    expect_out($sformatf("release%0d", k), 1'b0, 4'b0000, 8'h00);
  endtask

  initial begin
    data    = {8'h03, 8'h02, 8'h01, 8'h00};
    rst_n   = 1'b0;
    valid   = 4'b0000;
    i_ready = 1'b1;
    expect_out("reset", 1'b0, 4'b0000, 8'h00);
    tick();
    tick();
    rst_n = 1'b1;

    for (int c = 0; c < 5; c++) begin
      tick();
      expect_out($sformatf("idle%0d", c), 1'b0, 4'b0000, 8'h00);
    end

    // Single request
    valid = 4'b0100;
    expect_out("single_pre", 1'b0, 4'b0000, 8'h00);
    tick();
    expect_out("single_grant", 1'b1, 4'b0100, 8'h02);
    tick();
    expect_out("single_hold_a", 1'b1, 4'b0100, 8'h02);
    tick();
    expect_out("single_hold_b", 1'b1, 4'b0100, 8'h02);
    valid = 4'b0000;
    expect_out("single_drop", 1'b0, 4'b0000, 8'h00);

    // Rotation from a fresh reset
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    valid = 4'b1111;
    expect_out("rot_pre", 1'b0, 4'b0000, 8'h00);
    serve(0);
    serve(1);
    serve(2);
    serve(3);
    tick();
    expect_out("rot_gap", 1'b0, 4'b0000, 8'h00);
    valid = 4'b1111;
    expect_out("rot2_pre", 1'b0, 4'b0000, 8'h00);
    serve(0);
    serve(1);
    serve(2);
    serve(3);

    // Wrap: bring ptr to 2, then 0 and 1 requesting
    tick();
    valid = 4'b0100;
    expect_out("wrap_setup_pre", 1'b0, 4'b0000, 8'h00);
    serve(2);
    tick();
    valid = 4'b0011;
    expect_out("wrap_pre", 1'b0, 4'b0000, 8'h00);
    tick();
    expect_out("wrap_grant0", 1'b1, 4'b0001, 8'h00);
    valid = 4'b0010;
    expect_out("wrap_drop0", 1'b0, 4'b0000, 8'h00);
    tick();
    expect_out("wrap_grant1", 1'b1, 4'b0010, 8'h01);

    // Backpressure on grantee 1, with requester 0 also pending
    i_ready = 1'b0;
    valid   = 4'b0011;
    expect_out("bp_start", 1'b1, 4'b0000, 8'h01);
    for (int c = 0; c < 4; c++) begin
      tick();
      expect_out($sformatf("bp%0d", c), 1'b1, 4'b0000, 8'h01);
    end
    i_ready = 1'b1;
    expect_out("bp_release", 1'b1, 4'b0010, 8'h01);

    // Async reset while requester 3 is granted
    valid = 4'b1000;
    expect_out("r3_pre", 1'b0, 4'b0000, 8'h00);
    tick();
    expect_out("r3_grant", 1'b1, 4'b1000, 8'h03);
    valid = 4'b1001;
    expect_out("r3_hold", 1'b1, 4'b1000, 8'h03);
    rst_n = 1'b0;
    expect_out("async_rst", 1'b0, 4'b0000, 8'h00);
    rst_n = 1'b1;
    expect_out("post_rst", 1'b0, 4'b0000, 8'h00);
    tick();
    expect_out("post_rst_grant0", 1'b1, 4'b0001, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
